// File: rtl/seg_to_bcd.sv
// ---------------------------------------------------------------------------
// seg_to_bcd
//   Converts a stream of 7-segment display patterns into a packed BCD value.
//   Each accepted pattern is decoded to a decimal digit and shifted into the
//   value from the least-significant end. The value is handed to a consumer
//   once NDIG digits have arrived, or earlier when a pattern carries the
//   decimal point. An undecodable pattern flags Err and discards the
//   partial value.
//
// Parameters
//   NDIG        : BCD digits per assembled value (1..8)
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   Seg_in      : segment pattern, active high, bit0=a .. bit6=g, bit7=dp
//   Seg_valid   : Seg_in holds a pattern to transfer
//   Seg_ready   : block accepts a pattern this cycle (high unless holding)
//   Dout        : most recently accepted legal digit
//   Value       : assembled BCD value, least-significant digit in [3:0]
//   Value_valid : Value is complete and waiting for the consumer
//   Value_ready : consumer takes Value on this edge
//   Err         : one-cycle pulse after an illegal pattern was transferred
// ---------------------------------------------------------------------------
module seg_to_bcd #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        Seg_in,
  input  logic              Seg_valid,
  output logic              Seg_ready,
  output logic [3:0]        Dout,
  output logic [4*NDIG-1:0] Value,
  output logic              Value_valid,
  input  logic              Value_ready,
  output logic              Err
);

  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Returns {legal, digit}; the decimal point is not part of the lookup.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = {1'b1, 4'd0};
      7'h06:   res = {1'b1, 4'd1};
      7'h5B:   res = {1'b1, 4'd2};
      7'h4F:   res = {1'b1, 4'd3};
      7'h66:   res = {1'b1, 4'd4};
      7'h6D:   res = {1'b1, 4'd5};
      7'h7D:   res = {1'b1, 4'd6};
      7'h07:   res = {1'b1, 4'd7};
      7'h7F:   res = {1'b1, 4'd8};
      7'h6F:   res = {1'b1, 4'd9};
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4*NDIG-1:0] value_q, value_d;
  logic [3:0]        dout_q, dout_d;
  logic              err_q, err_d;

  logic              seg_ready;
  logic              value_valid;
  logic [4:0]        dec;
  logic              seg_legal;
  logic [3:0]        seg_digit;
  logic              xfer;
  logic [CW-1:0]     count_inc;
  logic              last_digit;
  logic              terminate;

  // Decode and transfer qualification
  always_comb begin
    dec        = seg_decode(Seg_in[6:0]);
    seg_legal  = dec[4];
    seg_digit  = dec[3:0];
    xfer       = Seg_valid & seg_ready;
    count_inc  = count_q + CW'(1);
    last_digit = (count_inc == LAST_CNT);
    // A dp on a legal digit closes the value early; upper digits stay zero.
    terminate  = last_digit | Seg_in[7];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (xfer) begin
          if (!seg_legal) begin
            state_d = IDLE;
          end else if (terminate) begin
            state_d = HOLD;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      HOLD: begin
        if (Value_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshake flags follow state only
  always_comb begin
    seg_ready   = (state_q != HOLD);
    value_valid = (state_q == HOLD);
  end

  // Datapath next values
  always_comb begin
    count_d = count_q;
    value_d = value_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (xfer) begin
          if (seg_legal) begin
            // Shift left one digit; the newest digit lands in [3:0].
            value_d      = value_q << 4;
            value_d[3:0] = seg_digit;
            dout_d       = seg_digit;
            count_d      = count_inc;
          end else begin
            // Illegal pattern: drop the partial value but keep the last
            // good digit visible on Dout.
            value_d = '0;
            count_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (Value_ready) begin
          value_d = '0;
          count_d = '0;
        end
      end
      default: begin
        value_d = '0;
        count_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      value_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      value_q <= value_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign Seg_ready   = seg_ready;
  assign Value_valid = value_valid;
  assign Value       = value_q;
  assign Dout        = dout_q;
  assign Err         = err_q;

endmodule

// File: tb/tb_seg_to_bcd.sv
module tb_seg_to_bcd;

  logic        clk;
  logic        rst;
  logic [7:0]  Seg_in;
  logic        Seg_valid;
  logic        Seg_ready;
  logic [3:0]  Dout;
  logic [15:0] Value;
  logic        Value_valid;
  logic        Value_ready;
  logic        Err;

  int total;
  int bad;

  seg_to_bcd #(.NDIG(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Seg_in     (Seg_in),
    .Seg_valid  (Seg_valid),
    .Seg_ready  (Seg_ready),
    .Dout       (Dout),
    .Value      (Value),
    .Value_valid(Value_valid),
    .Value_ready(Value_ready),
    .Err        (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  seg;
    logic        exp_err;
    logic [3:0]  exp_dout;
    logic        exp_vv;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs[15];
  logic [6:0] legal_codes[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " Value"}, 32'(Value), 32'h0);
    chk({tag, " Dout"}, 32'(Dout), 32'h0);
    chk({tag, " Value_valid"}, 32'(Value_valid), 32'h0);
    chk({tag, " Err"}, 32'(Err), 32'h0);
    chk({tag, " Seg_ready"}, 32'(Seg_ready), 32'h1);
  endtask

  // Leaves the bench 1 time unit after a rising edge with rst released.
  task automatic do_reset();
    Seg_valid   = 1'b0;
    Value_ready = 1'b0;
    Seg_in      = 8'h00;
    rst         = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send(input logic [7:0] s);
    Seg_in    = s;
    Seg_valid = 1'b1;
    step();
    Seg_valid = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    Seg_in      = 8'h00;
    Seg_valid   = 1'b0;
    Value_ready = 1'b0;

    vecs[0]  = '{8'h3F, 1'b0, 4'd0, 1'b0, 16'h0000};
    vecs[1]  = '{8'h06, 1'b0, 4'd1, 1'b0, 16'h0001};
    vecs[2]  = '{8'h5B, 1'b0, 4'd2, 1'b0, 16'h0002};
    vecs[3]  = '{8'h4F, 1'b0, 4'd3, 1'b0, 16'h0003};
    vecs[4]  = '{8'h66, 1'b0, 4'd4, 1'b0, 16'h0004};
    vecs[5]  = '{8'h6D, 1'b0, 4'd5, 1'b0, 16'h0005};
    vecs[6]  = '{8'h7D, 1'b0, 4'd6, 1'b0, 16'h0006};
    vecs[7]  = '{8'h07, 1'b0, 4'd7, 1'b0, 16'h0007};
    vecs[8]  = '{8'h7F, 1'b0, 4'd8, 1'b0, 16'h0008};
    vecs[9]  = '{8'h6F, 1'b0, 4'd9, 1'b0, 16'h0009};
    vecs[10] = '{8'hBF, 1'b0, 4'd0, 1'b1, 16'h0000};
    vecs[11] = '{8'hEF, 1'b0, 4'd9, 1'b1, 16'h0009};
    vecs[12] = '{8'hFF, 1'b0, 4'd8, 1'b1, 16'h0008};
    vecs[13] = '{8'h77, 1'b1, 4'd0, 1'b0, 16'h0000};
    vecs[14] = '{8'hF9, 1'b1, 4'd0, 1'b0, 16'h0000};

    legal_codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reset state, checked while rst is held low without a clock edge
    rst = 1'b0;
    #2;
    chk_idle_zero("reset_low");
    do_reset();
    chk_idle_zero("after_release");

    // Four digits, first transfer on the first edge after release
    send(8'h66);
    chk("s1 dout0", 32'(Dout), 32'h4);
    chk("s1 vv0", 32'(Value_valid), 32'h0);
    send(8'h4F);
    send(8'h5B);
    chk("s1 vv2", 32'(Value_valid), 32'h0);
    chk("s1 rdy2", 32'(Seg_ready), 32'h1);
    send(8'h06);
    chk("s1 vv", 32'(Value_valid), 32'h1);
    chk("s1 value", 32'(Value), 32'h4321);
    chk("s1 dout", 32'(Dout), 32'h1);
    chk("s1 seg_ready", 32'(Seg_ready), 32'h0);

    // Consumer stalls five cycles, then takes the value
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s2 hold value", 32'(Value), 32'h4321);
      chk("s2 hold vv", 32'(Value_valid), 32'h1);
    end
    Value_ready = 1'b1;
    step();
    Value_ready = 1'b0;
    chk("s2 vv", 32'(Value_valid), 32'h0);
    chk("s2 value", 32'(Value), 32'h0);
    chk("s2 seg_ready", 32'(Seg_ready), 32'h1);

    // No dead cycle: transfer right after the handoff, dp ends early
    send(8'h07);
    chk("s3 dout0", 32'(Dout), 32'h7);
    chk("s3 vv0", 32'(Value_valid), 32'h0);
    send(8'hED);
    chk("s3 vv", 32'(Value_valid), 32'h1);
    chk("s3 value", 32'(Value), 32'h0075);
    chk("s3 dout", 32'(Dout), 32'h5);

    // Pattern offered while holding is not consumed
    Seg_in    = 8'h06;
    Seg_valid = 1'b1;
    step();
    step();
    chk("s6 value", 32'(Value), 32'h0075);
    chk("s6 dout", 32'(Dout), 32'h5);
    chk("s6 vv", 32'(Value_valid), 32'h1);
    chk("s6 err", 32'(Err), 32'h0);
    Seg_valid   = 1'b0;
    Value_ready = 1'b1;
    step();
    Value_ready = 1'b0;
    chk("s6 released", 32'(Value_valid), 32'h0);

    // Value_ready outside HOLD does nothing
    Value_ready = 1'b1;
    send(8'h5B);
    Value_ready = 1'b0;
    chk("s7 value", 32'(Value), 32'h0002);
    chk("s7 rdy", 32'(Seg_ready), 32'h1);

    // Illegal pattern after a zero digit
    do_reset();
    send(8'h3F);
    chk("s4 dout0", 32'(Dout), 32'h0);
    send(8'h77);
    chk("s4 err", 32'(Err), 32'h1);
    chk("s4 value", 32'(Value), 32'h0);
    chk("s4 dout", 32'(Dout), 32'h0);
    chk("s4 rdy", 32'(Seg_ready), 32'h1);
    chk("s4 vv", 32'(Value_valid), 32'h0);
    step();
    chk("s4 err one cycle", 32'(Err), 32'h0);

    // Illegal pattern discards a non-zero partial value and its count
    send(8'h06);
    send(8'h5B);
    chk("s5 partial", 32'(Value), 32'h0012);
    send(8'h00);
    chk("s5 err", 32'(Err), 32'h1);
    chk("s5 value", 32'(Value), 32'h0);
    chk("s5 dout kept", 32'(Dout), 32'h2);
    send(8'h06);
    send(8'h06);
    send(8'h06);
    chk("s5 count cleared", 32'(Value_valid), 32'h0);
    send(8'h06);
    chk("s5 full vv", 32'(Value_valid), 32'h1);
    chk("s5 full value", 32'(Value), 32'h1111);

    // Reset dropped mid-collection
    do_reset();
    send(8'h6F);
    send(8'h6F);
    chk("s8 partial", 32'(Value), 32'h0099);
    #2;
    rst = 1'b0;
    #1;
    chk_idle_zero("s8 async");
    step();
    rst = 1'b1;
    step();
    chk_idle_zero("s8 release");
    for (int i = 0; i < 4; i++) send(8'h6F);
    chk("s8 value", 32'(Value), 32'h9999);
    chk("s8 vv", 32'(Value_valid), 32'h1);

    // Reset dropped while holding
    #2;
    rst = 1'b0;
    #1;
    chk_idle_zero("s9 async");
    step();
    rst = 1'b1;

    // Decode table, one transfer from a clean start per entry
    for (int i = 0; i < 15; i++) begin
      do_reset();
      send(vecs[i].seg);
      chk($sformatf("tbl[%0d] err", i), 32'(Err), 32'(vecs[i].exp_err));
      chk($sformatf("tbl[%0d] dout", i), 32'(Dout), 32'(vecs[i].exp_dout));
      chk($sformatf("tbl[%0d] vv", i), 32'(Value_valid), 32'(vecs[i].exp_vv));
      chk($sformatf("tbl[%0d] value", i), 32'(Value), 32'(vecs[i].exp_val));
    end

    // Sweep of every 7-bit code
    begin
      int n_legal;
      int n_err;
      n_legal = 0;
      n_err   = 0;
      for (int c = 0; c < 128; c++) begin
        logic exp_legal;
        exp_legal = 1'b0;
        for (int k = 0; k < 10; k++) begin
          if (legal_codes[k] == 7'(c)) exp_legal = 1'b1;
        end
        do_reset();
        send({1'b0, 7'(c)});
        if (Err) n_err++;
        else n_legal++;
        chk($sformatf("sweep 0x%02h err", c), 32'(Err), 32'(!exp_legal));
      end
      chk("sweep legal count", 32'(n_legal), 32'd10);
      chk("sweep err count", 32'(n_err), 32'd118);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
